// File: rtl/serial_demux_deser_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_demux_deser_if
// Description : Serial-bit input and parallel-word output handshake bundle
//               for serial_demux_deser.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_demux_deser_if #(
    parameter int WIDTH = 16
);
    localparam int c_IDX_W = $clog2(WIDTH);

    logic               flush;
    logic               bit_valid;
    logic               bit_in;
    logic               bit_ready;
    logic [WIDTH-1:0]   word_out;
    logic               word_valid;
    logic               word_ready;
    logic [c_IDX_W-1:0] bit_index;

    modport slave (
        input  flush, bit_valid, bit_in, word_ready,
        output bit_ready, word_out, word_valid, bit_index
    );

    modport master (
        output flush, bit_valid, bit_in, word_ready,
        input  bit_ready, word_out, word_valid, bit_index
    );
endinterface
`default_nettype wire

// File: rtl/serial_demux_deser.sv
`default_nettype none
// ============================================================================
// Module      : serial_demux_deser
// Description : 1-to-WIDTH sequential demux assembling a serial bit stream
//               into a parallel word with valid/ready output handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_demux_deser #(
    parameter int WIDTH     = 16,
    parameter int LSB_FIRST = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    serial_demux_deser_if.slave   sd
);
    localparam int                 c_IDX_W      = $clog2(WIDTH);
    localparam logic [c_IDX_W-1:0] c_LAST       = c_IDX_W'(WIDTH - 1);
    localparam logic [0:0]         c_ST_COLLECT = 1'b0;
    localparam logic [0:0]         c_ST_HOLD    = 1'b1;

    logic [0:0]         r_state;
    logic [WIDTH-1:0]   r_word;
    logic               r_word_valid;
    logic [c_IDX_W-1:0] r_bit_index;

    logic               w_bit_acc;
    logic               w_word_acc;
    logic [c_IDX_W-1:0] w_pos;

    generate
        if (LSB_FIRST != 0) begin : g_lsb_first
            assign w_pos = r_bit_index;
        end else begin : g_msb_first
            assign w_pos = c_LAST - r_bit_index;
        end
    endgenerate

    // In HOLD a new bit is only taken when the held word leaves the same cycle.
    assign sd.bit_ready  = (r_state == c_ST_COLLECT) ? 1'b1
                                                     : (sd.word_ready & ~sd.flush);
    assign w_bit_acc     = sd.bit_valid & sd.bit_ready;
    assign w_word_acc    = r_word_valid & sd.word_ready;

    assign sd.word_out   = r_word;
    assign sd.word_valid = r_word_valid;
    assign sd.bit_index  = r_bit_index;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_ST_COLLECT;
            r_word       <= '0;
            r_word_valid <= 1'b0;
            r_bit_index  <= '0;
        end else begin
            case (r_state)
                c_ST_COLLECT: begin
                    if (sd.flush) begin
                        r_bit_index <= '0;
                    end else if (w_bit_acc) begin
                        r_word[w_pos] <= sd.bit_in;
                        if (r_bit_index == c_LAST) begin
                            r_bit_index  <= '0;
                            r_word_valid <= 1'b1;
                            r_state      <= c_ST_HOLD;
                        end else begin
                            r_bit_index <= r_bit_index + c_IDX_W'(1);
                        end
                    end
                end
                c_ST_HOLD: begin
                    if (w_word_acc) begin
                        r_word_valid <= 1'b0;
                        r_state      <= c_ST_COLLECT;
                        // Index is 0 here, so w_pos is already the first slot.
                        if (w_bit_acc) begin
                            r_word[w_pos] <= sd.bit_in;
                            r_bit_index   <= c_IDX_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= c_ST_COLLECT;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_serial_demux_deser.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_demux_deser
// Description : Self-checking bench for serial_demux_deser, both bit orders.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_demux_deser;
    localparam int c_W = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    serial_demux_deser_if #(.WIDTH(c_W)) if_l ();
    serial_demux_deser_if #(.WIDTH(c_W)) if_m ();

    serial_demux_deser #(.WIDTH(c_W), .LSB_FIRST(1)) u_lsb (
        .clk   (clk),
        .reset (reset),
        .sd    (if_l.slave)
    );
    serial_demux_deser #(.WIDTH(c_W), .LSB_FIRST(0)) u_msb (
        .clk   (clk),
        .reset (reset),
        .sd    (if_m.slave)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference: queue of accepted bits; a word is formed when 16 are present.
    bit          m_q[$];
    bit          m_valid;
    logic [15:0] m_lsb;
    logic [15:0] m_msb;
    bit          m_fresh;

    typedef struct {
        logic [15:0] data;
        bit          msb_order;
        int          hold;
        logic [15:0] exp_lsb;
        logic [15:0] exp_msb;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit bv, input bit bi, input bit wr, input bit fl, input bit rst);
        reset          = rst;
        if_l.bit_valid = bv;  if_m.bit_valid  = bv;
        if_l.bit_in    = bi;  if_m.bit_in     = bi;
        if_l.word_ready = wr; if_m.word_ready = wr;
        if_l.flush     = fl;  if_m.flush      = fl;
    endtask

    task automatic step(input bit bv, input bit bi, input bit wr, input bit fl, input bit rst);
        bit exp_rdy;
        bit bacc;
        drive(bv, bi, wr, fl, rst);
        @(negedge clk);
        exp_rdy = !m_valid || (wr && !fl);
        check("bit_ready_l", 32'(if_l.bit_ready), 32'(exp_rdy));
        check("bit_ready_m", 32'(if_m.bit_ready), 32'(exp_rdy));
        check("word_valid_l", 32'(if_l.word_valid), 32'(m_valid));
        check("word_valid_m", 32'(if_m.word_valid), 32'(m_valid));
        check("bit_index_l", 32'(if_l.bit_index), 32'(m_q.size()));
        check("bit_index_m", 32'(if_m.bit_index), 32'(m_q.size()));
        if (m_valid || m_fresh) begin
            check("word_out_l", 32'(if_l.word_out), 32'(m_lsb));
            check("word_out_m", 32'(if_m.word_out), 32'(m_msb));
        end
        @(posedge clk);
        bacc    = bv && exp_rdy;
        m_fresh = 1'b0;
        if (rst) begin
            m_q.delete();
            m_valid = 1'b0;
            m_lsb   = '0;
            m_msb   = '0;
            m_fresh = 1'b1;
        end else if (!m_valid) begin
            if (fl) begin
                m_q.delete();
            end else if (bacc) begin
                m_q.push_back(bi);
                if (m_q.size() == 16) begin
                    m_lsb = '0;
                    m_msb = '0;
                    for (int i = 0; i < 16; i++) begin
                        m_lsb[i]      = m_q[i];
                        m_msb[15 - i] = m_q[i];
                    end
                    m_q.delete();
                    m_valid = 1'b1;
                end
            end
        end else if (wr) begin
            m_valid = 1'b0;
            if (bacc) m_q.push_back(bi);
        end
        #1;
    endtask

    task automatic send_word(input logic [15:0] data, input bit msb_order, input bit wr);
        for (int i = 0; i < 16; i++)
            step(1'b1, msb_order ? data[15 - i] : data[i], wr, 1'b0, 1'b0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"}, 32'(if_l.word_valid), 32'd0);
        check({tag, "_word"},  32'(if_l.word_out),   32'd0);
        check({tag, "_index"}, 32'(if_l.bit_index),  32'd0);
        check({tag, "_ready"}, 32'(if_l.bit_ready),  32'd1);
        check({tag, "_word_m"}, 32'(if_m.word_out),  32'd0);
    endtask

    int          vpos[$];
    logic [15:0] vval[$];

    initial begin
        vecs[0] = '{data: 16'hA5C3, msb_order: 1'b0, hold: 0, exp_lsb: 16'hA5C3, exp_msb: 16'hC3A5};
        vecs[1] = '{data: 16'h1234, msb_order: 1'b1, hold: 2, exp_lsb: 16'h2C48, exp_msb: 16'h1234};
        vecs[2] = '{data: 16'h00FF, msb_order: 1'b0, hold: 5, exp_lsb: 16'h00FF, exp_msb: 16'hFF00};
        vecs[3] = '{data: 16'hBEEF, msb_order: 1'b0, hold: 1, exp_lsb: 16'hBEEF, exp_msb: 16'hF77D};

        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        m_valid = 1'b0; m_lsb = '0; m_msb = '0; m_fresh = 1'b1;
        check_reset_state("reset");

        for (int v = 0; v < 4; v++) begin
            send_word(vecs[v].data, vecs[v].msb_order, 1'b1);
            for (int h = 0; h < vecs[v].hold; h++)
                step(1'b1, 1'($urandom), 1'b0, 1'b0, 1'b0);
            check("tbl_word_l", 32'(if_l.word_out), 32'(vecs[v].exp_lsb));
            check("tbl_word_m", 32'(if_m.word_out), 32'(vecs[v].exp_msb));
            check("tbl_valid",  32'(if_l.word_valid), 32'd1);
            step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        end

        // Backpressure then zero-bubble handoff
        send_word(16'h00FF, 1'b0, 1'b0);
        repeat (5) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check("handoff_index", 32'(if_l.bit_index), 32'd1);
        check("handoff_valid", 32'(if_l.word_valid), 32'd0);
        for (int i = 1; i < 16; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("handoff_word", 32'(if_l.word_out), 32'h0001);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Back-to-back words, ready tied high
        for (int i = 0; i < 33; i++) begin
            step(i < 32, (i < 16), 1'b1, 1'b0, 1'b0);
            if (if_l.word_valid) begin
                vpos.push_back(i);
                vval.push_back(if_l.word_out);
            end
        end
        check("b2b_pulses", 32'(vpos.size()), 32'd2);
        if (vpos.size() == 2) begin
            check("b2b_spacing", 32'(vpos[1] - vpos[0]), 32'd16);
            check("b2b_first",   32'(vval[0]), 32'hFFFF);
            check("b2b_second",  32'(vval[1]), 32'h0000);
        end

        // Flush after 7 bits; flush-cycle bit must not count
        for (int i = 0; i < 7; i++) step(1'b1, 1'((16'h0F0F >> i) & 1), 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        check("flush_index_l", 32'(if_l.bit_index), 32'd0);
        check("flush_index_m", 32'(if_m.bit_index), 32'd0);
        send_word(16'hBEEF, 1'b0, 1'b1);
        check("flush_word_l", 32'(if_l.word_out), 32'hBEEF);
        check("flush_word_m", 32'(if_m.word_out), 32'hF77D);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Reset mid-word and in HOLD
        for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_reset_state("rst_mid");
        send_word(16'h5A5A, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_reset_state("rst_hold");
        send_word(16'h8001, 1'b0, 1'b1);
        check("rst_after_l", 32'(if_l.word_out), 32'h8001);
        check("rst_after_m", 32'(if_m.word_out), 32'h8001);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Randomized traffic against the queue model
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 2) != 0,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 149) == 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
